// File: rtl/bist_sched.sv
// BIST campaign scheduler: walks the masked CUTs in ascending index order,
// runs one session per CUT on the shared BIST engine, and collects per-CUT
// pass flags plus aggregate FAIL / TIMEOUT_ERR results.
module bist_sched #(
  parameter int NUM_CUT = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ,
  input  logic [NUM_CUT-1:0] CUT_MASK,
  output logic               ENG_START,
  input  logic               ENG_FINISH,
  input  logic               ENG_BIST_END,
  input  logic               SIG_OK,
  output logic [1:0]         CUT_SEL,
  output logic               BUSY,
  output logic               DONE,
  output logic [NUM_CUT-1:0] PASS_VEC,
  output logic               FAIL,
  output logic               TIMEOUT_ERR
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_REPORT   = 3'd4;
  localparam logic [2:0] ST_WAIT_REL = 3'd5;

  // The session aborts on the RUN cycle in which the count reaches TIMEOUT.
  localparam logic [11:0] TIMER_LAST = 12'(TIMEOUT - 1);

  logic [2:0]         state_q,   state_d;
  logic [NUM_CUT-1:0] pending_q, pending_d;
  logic [NUM_CUT-1:0] mask_q,    mask_d;
  logic [NUM_CUT-1:0] pass_q,    pass_d;
  logic [1:0]         cut_sel_q, cut_sel_d;
  logic [11:0]        timer_q,   timer_d;
  logic               rel_q,     rel_d;
  logic               fail_q,    fail_d;
  logic               to_q,      to_d;
  logic [1:0]         next_sel;

  // Pick the lowest-index CUT still waiting for its session.
  always_comb begin
    next_sel = 2'd0;
    for (int i = NUM_CUT - 1; i >= 0; i--) begin
      if (pending_q[i]) next_sel = 2'(i);
    end
  end

  // Next-state and datapath update for the campaign sequencer.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    pass_d    = pass_q;
    cut_sel_d = cut_sel_q;
    timer_d   = timer_q;
    rel_d     = rel_q;
    fail_d    = fail_q;
    to_d      = to_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          mask_d    = CUT_MASK;
          pending_d = CUT_MASK;
          pass_d    = '0;
          fail_d    = 1'b0;
          to_d      = 1'b0;
          state_d   = (CUT_MASK == '0) ? ST_REPORT : ST_SELECT;
        end
      end
      ST_SELECT: begin
        cut_sel_d = next_sel;
        timer_d   = 12'd0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (timer_q != 12'hFFF) timer_d = timer_q + 12'd1;
        if (ENG_FINISH && ENG_BIST_END) begin
          for (int i = 0; i < NUM_CUT; i++) begin
            if (cut_sel_q == 2'(i)) begin
              pass_d[i]    = SIG_OK;
              pending_d[i] = 1'b0;
            end
          end
          rel_d   = 1'b0;
          state_d = ST_RELEASE;
        end else if (timer_q >= TIMER_LAST) begin
          for (int i = 0; i < NUM_CUT; i++) begin
            if (cut_sel_q == 2'(i)) begin
              pass_d[i]    = 1'b0;
              pending_d[i] = 1'b0;
            end
          end
          to_d    = 1'b1;
          rel_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!rel_q) begin
          rel_d = 1'b1;
        end else begin
          rel_d   = 1'b0;
          state_d = (pending_q != '0) ? ST_SELECT : ST_REPORT;
        end
      end
      ST_REPORT: begin
        fail_d  = |(mask_q & ~pass_q);
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!REQ) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      pass_q    <= '0;
      cut_sel_q <= 2'd0;
      timer_q   <= 12'd0;
      rel_q     <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      pass_q    <= pass_d;
      cut_sel_q <= cut_sel_d;
      timer_q   <= timer_d;
      rel_q     <= rel_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
    end
  end

  // Outputs decode straight from registered state so reset drops them at once.
  always_comb begin
    ENG_START   = (state_q == ST_RUN);
    BUSY        = (state_q != ST_IDLE) && (state_q != ST_WAIT_REL);
    DONE        = (state_q == ST_REPORT);
    CUT_SEL     = cut_sel_q;
    PASS_VEC    = pass_q;
    FAIL        = fail_q;
    TIMEOUT_ERR = to_q;
  end

endmodule

// File: tb/tb_bist_sched.sv
// Self-checking bench for bist_sched: directed campaign table, randomized
// campaigns against a campaign-level reference model, and hand-written
// held-request and mid-run reset sequences.
module tb_bist_sched;

  localparam int NUM_CUT = 4;
  localparam int TIMEOUT = 4095;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ;
  logic [3:0] CUT_MASK;
  logic       ENG_START;
  logic       ENG_FINISH;
  logic       ENG_BIST_END;
  logic       SIG_OK;
  logic [1:0] CUT_SEL;
  logic       BUSY;
  logic       DONE;
  logic [3:0] PASS_VEC;
  logic       FAIL;
  logic       TIMEOUT_ERR;

  int checks   = 0;
  int failures = 0;

  // Campaign record: lat[i] = RUN cycle on which the engine finishes CUT i
  // (0 = engine never finishes).
  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0]       sig;
    logic [3:0][12:0] lat;
    logic [3:0]       exp_pass;
    logic             exp_fail;
    logic             exp_to;
  } vec_t;

  vec_t tbl[7];

  int obs_edges;
  int obs_sess;
  int obs_done;
  bit obs_busy_ok;
  bit obs_order_ok;
  bit obs_stable_ok;

  bist_sched #(.NUM_CUT(NUM_CUT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .CUT_MASK(CUT_MASK),
    .ENG_START(ENG_START), .ENG_FINISH(ENG_FINISH), .ENG_BIST_END(ENG_BIST_END),
    .SIG_OK(SIG_OK), .CUT_SEL(CUT_SEL), .BUSY(BUSY), .DONE(DONE),
    .PASS_VEC(PASS_VEC), .FAIL(FAIL), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RUN length of one session: finish cycle, or TIMEOUT if the engine is silent.
  function automatic int session_len(input logic [12:0] l);
    return (l == 0 || int'(l) > TIMEOUT) ? TIMEOUT : int'(l);
  endfunction

  // Campaign-level reference: results and the number of clock edges from
  // request acceptance to the DONE cycle (1 to leave IDLE, then SELECT +
  // RUN + 2 RELEASE per session).
  function automatic void model(input vec_t v, output logic [3:0] p, output logic f,
                                output logic t, output int e);
    p = 4'b0;
    t = 1'b0;
    e = 1;
    for (int i = 0; i < 4; i++) begin
      if (v.mask[i]) begin
        e += 3 + session_len(v.lat[i]);
        if (v.lat[i] == 0 || int'(v.lat[i]) > TIMEOUT) t = 1'b1;
        else p[i] = v.sig[i];
      end
    end
    f = |(v.mask & ~p);
  endfunction

  // Run one campaign, acting as the BIST engine, and record what was seen.
  task automatic applyStimulus(input vec_t v, input bit hold_req);
    int   order[4];
    int   n = 0;
    int   run_cnt = 0;
    int   cur = 0;
    logic [1:0] sel_at_start = 2'd0;
    for (int i = 0; i < 4; i++) if (v.mask[i]) begin order[n] = i; n++; end
    obs_edges = 0; obs_sess = 0; obs_done = 0;
    obs_busy_ok = 1; obs_order_ok = 1; obs_stable_ok = 1;
    @(negedge CLK);
    CUT_MASK = v.mask;
    REQ = 1'b1;
    for (int cyc = 0; cyc < 20000 && obs_done == 0; cyc++) begin
      @(posedge CLK);
      obs_edges++;
      @(negedge CLK);
      if (cyc == 0) begin
        check_val("results cleared on accept", {PASS_VEC, FAIL, TIMEOUT_ERR}, 6'b0);
        if (!hold_req) REQ = 1'b0;
      end
      CUT_MASK     = 4'($urandom);
      ENG_FINISH   = 1'b0;
      ENG_BIST_END = 1'($urandom);
      SIG_OK       = 1'($urandom);
      if (!BUSY) obs_busy_ok = 0;
      if (ENG_START) begin
        run_cnt++;
        if (run_cnt == 1) begin
          if (obs_sess >= n || CUT_SEL !== 2'(order[obs_sess])) obs_order_ok = 0;
          cur = (obs_sess < n) ? order[obs_sess] : 0;
          sel_at_start = CUT_SEL;
          obs_sess++;
        end else if (CUT_SEL !== sel_at_start) begin
          obs_stable_ok = 0;
        end
        if (run_cnt == int'(v.lat[cur])) begin
          ENG_FINISH = 1'b1; ENG_BIST_END = 1'b1; SIG_OK = v.sig[cur];
        end else if ($urandom_range(0, 5) == 0) begin
          ENG_FINISH = 1'b1; ENG_BIST_END = 1'b0;
        end
      end else begin
        run_cnt = 0;
      end
      if (DONE) obs_done++;
    end
    ENG_FINISH = 1'b0;
    if (obs_done == 0) check_val("campaign DONE within budget", 0, 1);
    @(negedge CLK);
    check_val("DONE is a single pulse", {DONE, BUSY}, 2'b00);
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    logic [3:0] p; logic f; logic t; int e;
    model(v, p, f, t, e);
    check_val({tag, " PASS_VEC"}, PASS_VEC, v.exp_pass);
    check_val({tag, " FAIL"}, FAIL, v.exp_fail);
    check_val({tag, " TIMEOUT_ERR"}, TIMEOUT_ERR, v.exp_to);
    check_val({tag, " cycles to DONE"}, obs_edges, e);
    check_val({tag, " session count"}, obs_sess, $countones(v.mask));
    check_val({tag, " session order"}, obs_order_ok, 1);
    check_val({tag, " CUT_SEL stable"}, obs_stable_ok, 1);
    check_val({tag, " BUSY during campaign"}, obs_busy_ok, 1);
  endtask

  initial begin
    vec_t v;
    logic [3:0] p; logic f; logic t; int e;
    bit bad;
    int dones;

    RESET = 1'b1; REQ = 1'b0; CUT_MASK = 4'b0;
    ENG_FINISH = 1'b0; ENG_BIST_END = 1'b0; SIG_OK = 1'b0;

    // Directed campaigns with hand-derived expected results.
    tbl[0] = '{mask: 4'b1011, sig: 4'b1111, lat: {13'd7, 13'd0, 13'd3, 13'd5},
               exp_pass: 4'b1011, exp_fail: 1'b0, exp_to: 1'b0};
    tbl[1] = '{mask: 4'b0110, sig: 4'b1011, lat: {13'd4, 13'd4, 13'd4, 13'd4},
               exp_pass: 4'b0010, exp_fail: 1'b1, exp_to: 1'b0};
    tbl[2] = '{mask: 4'b0001, sig: 4'b1111, lat: {13'd0, 13'd0, 13'd0, 13'd0},
               exp_pass: 4'b0000, exp_fail: 1'b1, exp_to: 1'b1};
    tbl[3] = '{mask: 4'b0001, sig: 4'b1111, lat: {13'd0, 13'd0, 13'd0, 13'd4095},
               exp_pass: 4'b0001, exp_fail: 1'b0, exp_to: 1'b0};
    tbl[4] = '{mask: 4'b0000, sig: 4'b1111, lat: {13'd1, 13'd1, 13'd1, 13'd1},
               exp_pass: 4'b0000, exp_fail: 1'b0, exp_to: 1'b0};
    tbl[5] = '{mask: 4'b1111, sig: 4'b0101, lat: {13'd1, 13'd1, 13'd1, 13'd1},
               exp_pass: 4'b0101, exp_fail: 1'b1, exp_to: 1'b0};
    tbl[6] = '{mask: 4'b1000, sig: 4'b1000, lat: {13'd2, 13'd0, 13'd0, 13'd0},
               exp_pass: 4'b1000, exp_fail: 1'b0, exp_to: 1'b0};

    #12;
    check_val("reset outputs",
              {ENG_START, CUT_SEL, BUSY, DONE, PASS_VEC, FAIL, TIMEOUT_ERR}, 11'b0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    for (int k = 0; k < 7; k++) begin
      applyStimulus(tbl[k], 1'b0);
      checkOutput($sformatf("vec%0d", k), tbl[k]);
    end

    // Randomized campaigns with expectations from the reference model.
    for (int k = 0; k < 40; k++) begin
      v.mask = 4'($urandom);
      v.sig  = 4'($urandom);
      for (int i = 0; i < 4; i++) v.lat[i] = 13'($urandom_range(1, 30));
      model(v, p, f, t, e);
      v.exp_pass = p; v.exp_fail = f; v.exp_to = t;
      applyStimulus(v, 1'b0);
      checkOutput($sformatf("rand%0d", k), v);
    end

    // Held REQ: no second campaign until REQ drops.
    v = '{mask: 4'b0011, sig: 4'b0001, lat: {13'd2, 13'd2, 13'd2, 13'd2},
          exp_pass: 4'b0001, exp_fail: 1'b1, exp_to: 1'b0};
    applyStimulus(v, 1'b1);
    checkOutput("held", v);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (BUSY || DONE || ENG_START) bad = 1;
    end
    check_val("held REQ does not restart", bad, 0);
    check_val("held results kept", {PASS_VEC, FAIL}, 5'b00011);
    REQ = 1'b0;
    @(negedge CLK);
    v = '{mask: 4'b0100, sig: 4'b0100, lat: {13'd3, 13'd3, 13'd3, 13'd3},
          exp_pass: 4'b0100, exp_fail: 1'b0, exp_to: 1'b0};
    applyStimulus(v, 1'b0);
    checkOutput("restart", v);

    // Reset in the middle of CUT 1's session.
    @(negedge CLK);
    CUT_MASK = 4'b0011;
    REQ = 1'b1;
    bad = 1;
    for (int c = 0, r = 0; c < 200; c++) begin
      @(negedge CLK);
      REQ = 1'b0;
      ENG_FINISH = 1'b0; ENG_BIST_END = 1'b0; SIG_OK = 1'b0;
      if (ENG_START && CUT_SEL == 2'd0) begin
        ENG_FINISH = 1'b1; ENG_BIST_END = 1'b1; SIG_OK = 1'b1;
      end else if (ENG_START && CUT_SEL == 2'd1) begin
        r++;
        if (r == 3) begin bad = 0; break; end
      end
    end
    check_val("reached CUT 1 session", bad, 0);
    #2 RESET = 1'b1;
    #1;
    check_val("mid-run reset ENG_START", ENG_START, 0);
    check_val("mid-run reset outputs",
              {CUT_SEL, BUSY, DONE, PASS_VEC, FAIL, TIMEOUT_ERR}, 10'b0);
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (DONE) dones++;
      if (BUSY || ENG_START) bad = 1;
    end
    check_val("no DONE after aborted campaign", dones, 0);
    check_val("idle after reset release", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
